// File: rtl/inst_decode_queue.sv
// rtl/inst_decode_queue.sv - instruction decoder feeding a DEPTH-entry FIFO towards execute
// Each fetched word is split into opcode/OP1/OP2, the opcode expanded to one-hot, then queued.
module inst_decode_queue #(
  parameter  int INST_W = 16,
  parameter  int OPC_W  = 4,
  parameter  int OP1_W  = 4,
  parameter  int N_OPS  = 7,
  parameter  int DEPTH  = 4,
  localparam int OP2_W  = INST_W - OPC_W - OP1_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_SCLK,
  input  logic              i_RESETB,
  input  logic              i_WR_INST,
  input  logic [INST_W-1:0] i_DO,
  output logic              o_INST_RDY,
  output logic              o_VALID,
  input  logic              i_ACK,
  output logic [N_OPS-1:0]  o_OPCODE,
  output logic [OP1_W-1:0]  o_OP1,
  output logic [OP2_W-1:0]  o_OP2,
  output logic              o_ILLEGAL,
  output logic [CNT_W-1:0]  o_COUNT,
  output logic              o_ERR_OVF
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = N_OPS + 1 + OP1_W + OP2_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  // One bit wider than the opcode so N_OPS == 2**OPC_W does not wrap to zero
  localparam logic [OPC_W:0]   N_OPS_X  = (OPC_W + 1)'(N_OPS);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             err_ovf;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [OPC_W-1:0] dec_opc;
  logic [N_OPS-1:0] dec_onehot;
  logic             dec_illegal;
  logic [ENT_W-1:0] dec_entry;
  logic [ENT_W-1:0] head;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = i_WR_INST & ~full;
  assign pop   = i_ACK & ~empty;

  assign dec_opc = i_DO[INST_W-1 -: OPC_W];

  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (dec_opc == OPC_W'(i)) dec_onehot[i] = 1'b1;
    end
    dec_illegal = ({1'b0, dec_opc} >= N_OPS_X);
  end

  assign dec_entry = {dec_onehot, dec_illegal, i_DO[OP2_W +: OP1_W], i_DO[OP2_W-1:0]};

  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A rejected write is the only event that flags overflow; it stays until reset
      if (i_WR_INST && full) err_ovf <= 1'b1;
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

  assign o_INST_RDY = ~full;
  assign o_VALID    = ~empty;
  assign o_OPCODE   = head[ENT_W-1 -: N_OPS];
  assign o_ILLEGAL  = head[OP1_W + OP2_W];
  assign o_OP1      = head[OP2_W +: OP1_W];
  assign o_OP2      = head[OP2_W-1:0];
  assign o_COUNT    = count;
  assign o_ERR_OVF  = err_ovf;

endmodule

// File: tb/tb_inst_decode_queue.sv
// tb/tb_inst_decode_queue.sv - directed and random checks of inst_decode_queue against a queue model
module tb_inst_decode_queue;

  logic        i_SCLK = 1'b0;
  logic        i_RESETB;
  logic        i_WR_INST;
  logic [15:0] i_DO;
  logic        o_INST_RDY;
  logic        o_VALID;
  logic        i_ACK;
  logic [6:0]  o_OPCODE;
  logic [3:0]  o_OP1;
  logic [7:0]  o_OP2;
  logic        o_ILLEGAL;
  logic [2:0]  o_COUNT;
  logic        o_ERR_OVF;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mq [$];
  logic        m_err;

  inst_decode_queue dut (
    .i_SCLK    (i_SCLK),
    .i_RESETB  (i_RESETB),
    .i_WR_INST (i_WR_INST),
    .i_DO      (i_DO),
    .o_INST_RDY(o_INST_RDY),
    .o_VALID   (o_VALID),
    .i_ACK     (i_ACK),
    .o_OPCODE  (o_OPCODE),
    .o_OP1     (o_OP1),
    .o_OP2     (o_OP2),
    .o_ILLEGAL (o_ILLEGAL),
    .o_COUNT   (o_COUNT),
    .o_ERR_OVF (o_ERR_OVF)
  );

  always #5 i_SCLK = ~i_SCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs straight from the queue contents: opcode = top nibble, legal if below 7
  task automatic check_model(input string tag);
    logic [15:0] w;
    int          opc;
    logic [6:0]  oh;
    w   = (mq.size() > 0) ? mq[0] : 16'h0000;
    opc = int'(w[15:12]);
    oh  = (mq.size() > 0 && opc < 7) ? 7'(1 << opc) : 7'd0;
    chk({tag, ".valid"}, 32'(o_VALID),    32'(mq.size() > 0));
    chk({tag, ".count"}, 32'(o_COUNT),    32'(mq.size()));
    chk({tag, ".rdy"},   32'(o_INST_RDY), 32'(mq.size() != 4));
    chk({tag, ".ovf"},   32'(o_ERR_OVF),  32'(m_err));
    chk({tag, ".opc"},   32'(o_OPCODE),   32'(oh));
    chk({tag, ".ill"},   32'(o_ILLEGAL),  32'(mq.size() > 0 && opc >= 7));
    chk({tag, ".op1"},   32'(o_OP1),      32'(w[11:8]));
    chk({tag, ".op2"},   32'(o_OP2),      32'(w[7:0]));
  endtask

  task automatic cyc(input logic wr, input logic [15:0] d, input logic ack, input string tag);
    int sz;
    i_WR_INST = wr;
    i_DO      = d;
    i_ACK     = ack;
    @(posedge i_SCLK);
    sz = mq.size();
    if (wr && sz == 4) m_err = 1'b1;
    if (ack && sz > 0) void'(mq.pop_front());
    if (wr && sz < 4) mq.push_back(d);
    #1;
    i_WR_INST = 1'b0;
    i_ACK     = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    i_WR_INST = 1'b0;
    i_ACK     = 1'b0;
    i_RESETB  = 1'b0;
    mq.delete();
    m_err = 1'b0;
    #1;
    check_model({tag, ".async"});
    @(posedge i_SCLK);
    #1;
    i_RESETB = 1'b1;
    check_model({tag, ".rel"});
  endtask

  initial begin
    i_RESETB  = 1'b0;
    i_WR_INST = 1'b0;
    i_ACK     = 1'b0;
    i_DO      = 16'h0000;
    mq.delete();
    m_err = 1'b0;
    #1;
    check_model("por");
    @(posedge i_SCLK);
    #1;
    i_RESETB = 1'b1;

    // Asynchronous reset with three entries queued
    cyc(1'b1, 16'h1111, 1'b0, "r_fill");
    cyc(1'b1, 16'h2222, 1'b0, "r_fill");
    cyc(1'b1, 16'h3333, 1'b0, "r_fill");
    chk("r_cnt3", 32'(o_COUNT), 32'd3);
    do_reset("rst_mid");
    chk("rst_cnt0", 32'(o_COUNT), 32'd0);
    chk("rst_rdy1", 32'(o_INST_RDY), 32'd1);

    // Decode
    cyc(1'b1, 16'h4A5C, 1'b0, "dec1");
    chk("dec1_opc_const", 32'(o_OPCODE), 32'h10);
    chk("dec1_op1_const", 32'(o_OP1), 32'hA);
    chk("dec1_op2_const", 32'(o_OP2), 32'h5C);
    cyc(1'b1, 16'h0123, 1'b1, "dec2");
    chk("dec2_opc_const", 32'(o_OPCODE), 32'h01);
    cyc(1'b0, 16'h0000, 1'b1, "dec_pop");

    // Illegal opcode
    cyc(1'b1, 16'hF0FF, 1'b0, "ill");
    chk("ill_flag_const", 32'(o_ILLEGAL), 32'd1);
    chk("ill_op2_const",  32'(o_OP2), 32'hFF);
    cyc(1'b0, 16'h0000, 1'b1, "ill_pop");

    // Boundary opcode 6 (last legal) and 7 (first illegal)
    cyc(1'b1, 16'h6789, 1'b0, "opc6");
    cyc(1'b1, 16'h7ABC, 1'b1, "opc7");
    cyc(1'b0, 16'h0000, 1'b1, "opc_pop");

    // Fill, overflow, drain in order
    for (int i = 1; i <= 5; i++) cyc(1'b1, 16'(16'h1000 * i + i), 1'b0, "full_push");
    chk("full_cnt_const", 32'(o_COUNT), 32'd4);
    chk("full_ovf_const", 32'(o_ERR_OVF), 32'd1);
    cyc(1'b1, 16'h5555, 1'b1, "full_pushpop");
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b1, "drain");
    chk("drain_valid_const", 32'(o_VALID), 32'd0);
    chk("drain_ovf_const", 32'(o_ERR_OVF), 32'd1);

    // Empty ack after reset
    do_reset("rst2");
    cyc(1'b0, 16'h0000, 1'b1, "empty_ack");
    chk("empty_ack_ovf", 32'(o_ERR_OVF), 32'd0);

    // Streaming with push and ack every cycle, pointers wrap
    cyc(1'b1, 16'h0100, 1'b0, "strm0");
    for (int i = 1; i < 10; i++) begin
      cyc(1'b1, 16'((i % 8) << 12 | (i << 4) | i), 1'b1, "strm");
      chk("strm_cnt1", 32'(o_COUNT), 32'd1);
    end
    cyc(1'b0, 16'h0000, 1'b1, "strm_end");

    // Random push/ack against the model
    do_reset("rst3");
    for (int i = 0; i < 1000; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
